// File: rtl/exception_unit.sv
// exception_unit: precise-exception collector sitting between the pipeline
// and coprocessor 0. A shadow pipeline carries one 3-bit cause per
// instruction (ID/EX/MEM). At MEM commit a single cause is selected, reported
// to CP0 as a one-hot pulse with EPC/BadVAddr, and fetch is redirected to the
// kernel vector while flush drains the pipeline. ERET redirects fetch to EPC.
module exception_unit #(
    parameter logic [31:0] KERNEL_PC    = 32'h8000_0180,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        if_addrl,
    input  logic [31:0] if_pc,
    input  logic        id_ri,
    input  logic        id_sys,
    input  logic        id_tr,
    input  logic        ex_ovf,
    input  logic        mem_addrs,
    input  logic        mem_addrl,
    input  logic [31:0] mem_addr,
    input  logic        int_ext_req,
    input  logic        exc_level,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        int_ext,
    output logic        int_tr,
    output logic        int_ovf,
    output logic        int_ri,
    output logic        int_sys,
    output logic        int_addrs,
    output logic        int_addrl,
    output logic [31:0] epc_in,
    output logic [31:0] badvaddr_in,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        busy
);

    // Cause ids; value N drives bit N-1 of the one-hot pulse vector
    // {ext, tr, ovf, ri, sys, addrs, addrl}.
    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_ADDRL = 3'd1;
    localparam logic [2:0] C_ADDRS = 3'd2;
    localparam logic [2:0] C_SYS   = 3'd3;
    localparam logic [2:0] C_RI    = 3'd4;
    localparam logic [2:0] C_OVF   = 3'd5;
    localparam logic [2:0] C_TR    = 3'd6;
    localparam logic [2:0] C_EXT   = 3'd7;

    // Number of DRAIN cycles following the single RAISE cycle.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAISE = 2'd1,
        S_DRAIN = 2'd2,
        S_ERET  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  code_id_q, code_id_d;
    logic [2:0]  code_ex_q, code_ex_d;
    logic [2:0]  code_mem_q, code_mem_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pc_ex_q, pc_ex_d;
    logic [31:0] pc_mem_q, pc_mem_d;
    logic [6:0]  int_vec_q, int_vec_d;
    logic [31:0] epc_in_q, epc_in_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic [31:0] target_q, target_d;

    logic [2:0]  commit_cause;
    logic [2:0]  raise_cause;
    logic        take_sync;
    logic        take_eret;
    logic        take_ext;

    // Decode a cause id into the CP0 one-hot pulse vector.
    function automatic logic [6:0] cause_onehot(input logic [2:0] cause);
        logic [6:0] vec;
        vec = 7'b0;
        case (cause)
            C_ADDRL: vec = 7'b000_0001;
            C_ADDRS: vec = 7'b000_0010;
            C_SYS:   vec = 7'b000_0100;
            C_RI:    vec = 7'b000_1000;
            C_OVF:   vec = 7'b001_0000;
            C_TR:    vec = 7'b010_0000;
            C_EXT:   vec = 7'b100_0000;
            default: vec = 7'b0;
        endcase
        return vec;
    endfunction

    // Shadow pipeline: advance with the datapath; an older stage's cause
    // always beats anything detected later; flushed slots carry nothing.
    always_comb begin
        code_id_d  = code_id_q;
        code_ex_d  = code_ex_q;
        code_mem_d = code_mem_q;
        pc_id_d    = pc_id_q;
        pc_ex_d    = pc_ex_q;
        pc_mem_d   = pc_mem_q;
        if (state_q != S_IDLE) begin
            code_id_d  = C_NONE;
            code_ex_d  = C_NONE;
            code_mem_d = C_NONE;
        end else if (!stall) begin
            code_id_d = if_addrl ? C_ADDRL : C_NONE;
            if (code_id_q != C_NONE) code_ex_d = code_id_q;
            else if (id_ri)          code_ex_d = C_RI;
            else if (id_sys)         code_ex_d = C_SYS;
            else if (id_tr)          code_ex_d = C_TR;
            else                     code_ex_d = C_NONE;
            if (code_ex_q != C_NONE) code_mem_d = code_ex_q;
            else if (ex_ovf)         code_mem_d = C_OVF;
            else                     code_mem_d = C_NONE;
            pc_id_d  = if_pc;
            pc_ex_d  = pc_id_q;
            pc_mem_d = pc_ex_q;
        end
    end

    // Commit arbitration in MEM: synchronous cause > eret > interrupt;
    // Status.EXL masks every cause.
    always_comb begin
        if (code_mem_q != C_NONE) commit_cause = code_mem_q;
        else if (mem_addrs)       commit_cause = C_ADDRS;
        else if (mem_addrl)       commit_cause = C_ADDRL;
        else                      commit_cause = C_NONE;
        take_sync   = (commit_cause != C_NONE) && !exc_level;
        take_eret   = eret && !take_sync;
        take_ext    = (commit_cause == C_NONE) && !eret && int_ext_req && !exc_level;
        raise_cause = take_sync ? commit_cause : C_EXT;
    end

    // Next state and next registered outputs; outputs reflect the state
    // being entered so pulses appear one cycle after commit is sampled.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        int_vec_d  = 7'b0;
        redirect_d = 1'b0;
        flush_d    = 1'b0;
        epc_in_d   = epc_in_q;
        badvaddr_d = badvaddr_q;
        target_d   = target_q;
        case (state_q)
            S_IDLE: begin
                if (take_sync || take_ext) begin
                    state_d    = S_RAISE;
                    int_vec_d  = cause_onehot(raise_cause);
                    epc_in_d   = pc_mem_q;
                    if (raise_cause == C_ADDRL || raise_cause == C_ADDRS)
                        badvaddr_d = mem_addr;
                    flush_d    = 1'b1;
                    redirect_d = 1'b1;
                    target_d   = KERNEL_PC;
                end else if (take_eret) begin
                    state_d    = S_ERET;
                    flush_d    = 1'b1;
                    redirect_d = 1'b1;
                    target_d   = epc;
                end
            end
            S_RAISE: begin
                if (DRAIN_LOAD == 4'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                    flush_d = 1'b1;
                end
            end
            S_DRAIN: begin
                cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_IDLE;
                else               flush_d = 1'b1;
            end
            S_ERET: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, shadow pipeline and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            code_id_q  <= C_NONE;
            code_ex_q  <= C_NONE;
            code_mem_q <= C_NONE;
            pc_id_q    <= 32'd0;
            pc_ex_q    <= 32'd0;
            pc_mem_q   <= 32'd0;
            int_vec_q  <= 7'b0;
            epc_in_q   <= 32'd0;
            badvaddr_q <= 32'd0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            target_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_id_q  <= code_id_d;
            code_ex_q  <= code_ex_d;
            code_mem_q <= code_mem_d;
            pc_id_q    <= pc_id_d;
            pc_ex_q    <= pc_ex_d;
            pc_mem_q   <= pc_mem_d;
            int_vec_q  <= int_vec_d;
            epc_in_q   <= epc_in_d;
            badvaddr_q <= badvaddr_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
        end
    end

    assign int_addrl   = int_vec_q[0];
    assign int_addrs   = int_vec_q[1];
    assign int_sys     = int_vec_q[2];
    assign int_ri      = int_vec_q[3];
    assign int_ovf     = int_vec_q[4];
    assign int_tr      = int_vec_q[5];
    assign int_ext     = int_vec_q[6];
    assign epc_in      = epc_in_q;
    assign badvaddr_in = badvaddr_q;
    assign flush       = flush_q;
    assign pc_redirect = redirect_q;
    assign pc_target   = target_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_exception_unit.sv
// Testbench for exception_unit: directed sequences, a table of single-commit
// vectors, and randomized traffic against an instruction-level model.
module tb_exception_unit;

    localparam logic [31:0] KPC = 32'h8000_0180;
    localparam int          DC  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, if_addrl, id_ri, id_sys, id_tr, ex_ovf;
    logic        mem_addrs, mem_addrl, int_ext_req, exc_level, eret;
    logic [31:0] if_pc, mem_addr, epc;
    logic        int_ext, int_tr, int_ovf, int_ri, int_sys, int_addrs, int_addrl;
    logic [31:0] epc_in, badvaddr_in, pc_target;
    logic        flush, pc_redirect, busy;
    logic [6:0]  int_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exception_unit #(.KERNEL_PC(KPC), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .if_addrl(if_addrl), .if_pc(if_pc),
        .id_ri(id_ri), .id_sys(id_sys), .id_tr(id_tr), .ex_ovf(ex_ovf),
        .mem_addrs(mem_addrs), .mem_addrl(mem_addrl), .mem_addr(mem_addr),
        .int_ext_req(int_ext_req), .exc_level(exc_level), .eret(eret), .epc(epc),
        .int_ext(int_ext), .int_tr(int_tr), .int_ovf(int_ovf), .int_ri(int_ri),
        .int_sys(int_sys), .int_addrs(int_addrs), .int_addrl(int_addrl),
        .epc_in(epc_in), .badvaddr_in(badvaddr_in), .flush(flush),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .busy(busy)
    );

    // Pulse vector order: {ext, tr, ovf, ri, sys, addrs, addrl}
    assign int_vec = {int_ext, int_tr, int_ovf, int_ri, int_sys, int_addrs, int_addrl};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        stall = 0; if_addrl = 0; id_ri = 0; id_sys = 0; id_tr = 0; ex_ovf = 0;
        mem_addrs = 0; mem_addrl = 0; int_ext_req = 0; exc_level = 0; eret = 0;
        mem_addr = 32'd0; epc = 32'd0;
    endtask

    // Control bundle {int_vec, pc_redirect, flush, busy}
    task automatic check_ctl(input string name, input logic [6:0] iv, input logic rd,
                             input logic fl, input logic bz);
        check(name, {int_vec, pc_redirect, flush, busy}, {iv, rd, fl, bz});
    endtask

    // Ticks until busy drops (bounded); returns number of busy cycles seen.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 30) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_inputs();
        if_pc = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- table of single-commit vectors ----------------
    typedef struct packed {
        logic        addrs;
        logic        addrl;
        logic        ext;
        logic        exl;
        logic        er;
        logic [31:0] maddr;
        logic [31:0] epcv;
        logic [6:0]  exp_int;
        logic        exp_redir;
        logic [31:0] exp_tgt;
        logic [31:0] exp_bva;
        logic [3:0]  exp_busy;
    } vec_t;

    // ---------------- randomized-phase model ----------------
    // Each stage holds the instruction's PC and the set of exceptions seen so
    // far; at commit the earliest one in program-detection order is reported.
    localparam int FL_IFAL = 0, FL_RI = 1, FL_SYS = 2, FL_TR = 3, FL_OVF = 4;
    logic [31:0] m_pc [3];
    logic [7:0]  m_fl [3];
    int          m_left;
    logic [6:0]  e_int;
    logic        e_redir;
    logic [31:0] e_epc, e_bva, e_tgt;

    // Returns pulse-vector bit of the reported cause, or -1 for none.
    function automatic int pick(input logic [7:0] fl, input logic as, input logic al);
        if (fl[FL_IFAL]) return 0;
        if (fl[FL_RI])   return 3;
        if (fl[FL_SYS])  return 2;
        if (fl[FL_TR])   return 5;
        if (fl[FL_OVF])  return 4;
        if (as)          return 1;
        if (al)          return 0;
        return -1;
    endfunction

    task automatic model_step();
        int c;
        e_int   = 7'b0;
        e_redir = 1'b0;
        if (m_left > 0) begin
            m_left--;
            for (int i = 0; i < 3; i++) m_fl[i] = 8'd0;
        end else begin
            c = pick(m_fl[2], mem_addrs, mem_addrl);
            if (c >= 0 && !exc_level) begin
                e_int = 7'(1 << c);
                e_epc = m_pc[2];
                if (c <= 1) e_bva = mem_addr;
                e_redir = 1'b1;
                e_tgt   = KPC;
                m_left  = DC;
            end else if (eret) begin
                e_redir = 1'b1;
                e_tgt   = epc;
                m_left  = 1;
            end else if (c < 0 && int_ext_req && !exc_level) begin
                e_int   = 7'b100_0000;
                e_epc   = m_pc[2];
                e_redir = 1'b1;
                e_tgt   = KPC;
                m_left  = DC;
            end
            if (!stall) begin
                m_fl[2] = m_fl[1] | (ex_ovf ? 8'(1 << FL_OVF) : 8'd0);
                m_fl[1] = m_fl[0] | (id_ri ? 8'(1 << FL_RI) : 8'd0)
                                  | (id_sys ? 8'(1 << FL_SYS) : 8'd0)
                                  | (id_tr ? 8'(1 << FL_TR) : 8'd0);
                m_fl[0] = if_addrl ? 8'(1 << FL_IFAL) : 8'd0;
                m_pc[2] = m_pc[1];
                m_pc[1] = m_pc[0];
                m_pc[0] = if_pc;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   n;

        tbl[0] = '{0,1,0,0,0, 32'h1000_0003, 32'h0, 7'b000_0001, 1, KPC,          32'h1000_0003, 4'd3};
        tbl[1] = '{1,0,0,0,0, 32'h2000_0001, 32'h0, 7'b000_0010, 1, KPC,          32'h2000_0001, 4'd3};
        tbl[2] = '{1,1,0,0,0, 32'h3000_0002, 32'h0, 7'b000_0010, 1, KPC,          32'h3000_0002, 4'd3};
        tbl[3] = '{0,0,0,0,1, 32'h0, 32'h0040_0100, 7'b000_0000, 1, 32'h0040_0100, 32'h3000_0002, 4'd1};
        tbl[4] = '{0,0,1,1,0, 32'h0, 32'h0,         7'b000_0000, 0, 32'h0040_0100, 32'h3000_0002, 4'd0};
        tbl[5] = '{0,0,1,0,0, 32'h0, 32'h0,         7'b100_0000, 1, KPC,          32'h3000_0002, 4'd3};
        tbl[6] = '{1,0,1,0,0, 32'h4000_0004, 32'h0, 7'b000_0010, 1, KPC,          32'h4000_0004, 4'd3};
        tbl[7] = '{0,0,1,0,1, 32'h0, 32'h0040_0200, 7'b000_0000, 1, 32'h0040_0200, 32'h4000_0004, 4'd1};
        tbl[8] = '{0,1,0,1,0, 32'h5000_0000, 32'h0, 7'b000_0000, 0, 32'h0040_0200, 32'h4000_0004, 4'd0};
        tbl[9] = '{1,0,0,0,1, 32'h6000_0006, 32'h0040_0300, 7'b000_0010, 1, KPC,  32'h6000_0006, 4'd3};

        // Reset state
        reset = 1'b1;
        clr_inputs();
        if_pc = 32'd0;
        tick();
        check_ctl("reset_ctl", 7'b0, 0, 0, 0);
        check("reset_epc", epc_in, 32'd0);
        check("reset_bva", badvaddr_in, 32'd0);
        check("reset_tgt", pc_target, 32'd0);
        reset = 1'b0;
        tick();

        // Syscall reaches MEM two cycles after ID, pulses once, drains 3 cycles
        if_pc = 32'h0040_0010; tick();
        id_sys = 1; if_pc = 32'h0040_0014; tick();
        id_sys = 0; if_pc = 32'h0040_0018; tick();
        check_ctl("sys_in_mem", 7'b0, 0, 0, 0);
        tick();
        check_ctl("sys_raise", 7'b000_0100, 1, 1, 1);
        check("sys_epc", epc_in, 32'h0040_0010);
        check("sys_tgt", pc_target, KPC);
        tick(); check_ctl("sys_drain1", 7'b0, 0, 1, 1);
        tick(); check_ctl("sys_drain2", 7'b0, 0, 1, 1);
        tick(); check_ctl("sys_idle", 7'b0, 0, 0, 0);

        // Fetch misalign beats a later overflow on the same instruction
        if_pc = 32'h0040_0041; if_addrl = 1; tick();
        if_addrl = 0; if_pc = 32'h0040_0045; tick();
        ex_ovf = 1; tick();
        ex_ovf = 0; tick();
        check_ctl("ifal_over_ovf", 7'b000_0001, 1, 1, 1);
        check("ifal_epc", epc_in, 32'h0040_0041);
        wait_idle(n);
        tick(); tick();
        check_ctl("ovf_not_reported", 7'b0, 0, 0, 0);

        // Interrupt masked by EXL, then taken with pc_mem as EPC
        exc_level = 1; int_ext_req = 1; if_pc = 32'h0040_0800;
        tick(); check_ctl("ext_masked1", 7'b0, 0, 0, 0);
        tick(); check_ctl("ext_masked2", 7'b0, 0, 0, 0);
        tick(); check_ctl("ext_masked3", 7'b0, 0, 0, 0);
        exc_level = 0; tick();
        check_ctl("ext_taken", 7'b100_0000, 1, 1, 1);
        check("ext_epc", epc_in, 32'h0040_0800);
        int_ext_req = 0;
        wait_idle(n);
        check("ext_busy_len", n, DC);
        int_ext_req = 1; mem_addrs = 1; mem_addr = 32'h7000_0001; tick();
        check_ctl("addrs_over_ext", 7'b000_0010, 1, 1, 1);
        check("addrs_bva", badvaddr_in, 32'h7000_0001);
        clr_inputs();
        wait_idle(n);

        // Asynchronous reset in the last DRAIN cycle, then a normal RI
        mem_addrl = 1; mem_addr = 32'h1000_0003; tick();
        clr_inputs();
        tick(); tick();
        check_ctl("pre_reset_drain", 7'b0, 0, 1, 1);
        #3 reset = 1'b1;
        #1;
        check_ctl("async_reset", 7'b0, 0, 0, 0);
        check("async_reset_tgt", pc_target, 32'd0);
        #1 reset = 1'b0;
        if_pc = 32'h0040_0900; tick();
        id_ri = 1; if_pc = 32'h0040_0904; tick();
        id_ri = 0; tick();
        tick();
        check_ctl("ri_after_reset", 7'b000_1000, 1, 1, 1);
        check("ri_epc", epc_in, 32'h0040_0900);
        wait_idle(n);

        // Table of single-cycle MEM commits
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mem_addrs = tbl[i].addrs; mem_addrl = tbl[i].addrl;
            int_ext_req = tbl[i].ext; exc_level = tbl[i].exl; eret = tbl[i].er;
            mem_addr = tbl[i].maddr; epc = tbl[i].epcv;
            tick();
            clr_inputs();
            check($sformatf("tbl%0d_int", i), int_vec, tbl[i].exp_int);
            check($sformatf("tbl%0d_redir", i), pc_redirect, tbl[i].exp_redir);
            check($sformatf("tbl%0d_tgt", i), pc_target, tbl[i].exp_tgt);
            check($sformatf("tbl%0d_bva", i), badvaddr_in, tbl[i].exp_bva);
            wait_idle(n);
            check($sformatf("tbl%0d_busy", i), n, tbl[i].exp_busy);
        end

        // Randomized traffic against the instruction-level model
        do_reset();
        for (int i = 0; i < 3; i++) begin
            m_pc[i] = 32'd0;
            m_fl[i] = 8'd0;
        end
        m_left = 0; e_epc = 0; e_bva = 0; e_tgt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            stall       = ($urandom_range(0, 7) == 0);
            if_addrl    = ($urandom_range(0, 15) == 0);
            id_ri       = ($urandom_range(0, 15) == 0);
            id_sys      = ($urandom_range(0, 15) == 0);
            id_tr       = ($urandom_range(0, 15) == 0);
            ex_ovf      = ($urandom_range(0, 15) == 0);
            mem_addrs   = ($urandom_range(0, 19) == 0);
            mem_addrl   = ($urandom_range(0, 19) == 0);
            int_ext_req = ($urandom_range(0, 9) == 0);
            exc_level   = ($urandom_range(0, 7) == 0);
            eret        = !exc_level && ($urandom_range(0, 15) == 0);
            if_pc       = $urandom;
            mem_addr    = $urandom;
            epc         = $urandom;
            model_step();
            tick();
            check("rnd_ctl", {int_vec, pc_redirect, flush, busy},
                  {e_int, e_redir, m_left > 0, m_left > 0});
            check("rnd_epc", epc_in, e_epc);
            check("rnd_bva", badvaddr_in, e_bva);
            check("rnd_tgt", pc_target, e_tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
